qspi_phase_sequencer: RTL and testbench
=======================================

// Module: qspi_phase_sequencer
// PURPOSE
//  Sequences one QSPI flash transaction through CMD, ADDR, DUMMY and DATA phases.
//  Phase lengths are timed with one external qspi_counter instance; the sequencer
//  drives cnt_start and cnt_target and advances on cnt_done.
//  Sits between the AHB-side register/command logic and the QSPI shift datapath.
//  Publishes the current phase, the lane mode and chip-select.
// PARAMETERS
//  MAX_BYTES       8   max data bytes per transaction (data_bytes range 0..MAX_BYTES)
//  CS_HOLD_CYCLES  2   CS_HOLD phase length in clk cycles, legal range 2..31
//  BW              $clog2(MAX_BYTES+1)   width of byte count fields
// PORTS
//  clk           in   1   system clock; one QSPI bit-slot per clk
//  rst           in   1   synchronous reset, active-high
//  start         in   1   launch transaction; sampled only in IDLE
//  abort         in   1   terminate transaction immediately
//  addr_en       in   1   include 24-bit ADDR phase
//  cmd_quad      in   1   CMD phase on 4 lanes (else 1 lane)
//  addr_quad     in   1   ADDR phase on 4 lanes
//  data_quad     in   1   DATA phase on 4 lanes
//  dummy_cycles  in   5   DUMMY phase length; 0 = skip phase
//  data_bytes    in   BW  number of data bytes; 0 = skip phase
//  cnt_done      in   1   from qspi_counter.count_done
//  cnt_start     out  1   to qspi_counter.start_count
//  cnt_target    out  5   to qspi_counter.target_count
//  cs_n          out  1   flash chip select, active-low
//  phase         out  3   0 IDLE, 1 CMD, 2 ADDR, 3 DUMMY, 4 DATA, 5 CS_HOLD, 6 DONE
//  quad          out  1   current phase uses 4 lanes
//  byte_idx      out  BW  index of the data byte in flight (0-based)
//  busy          out  1   high in every state except IDLE
//  done          out  1   one-cycle pulse on normal completion
// BEHAVIOUR
//  - Reset, sync-high, overrides everything including mid-transaction:
//    IDLE, cs_n=1, cnt_start=0, cnt_target=0, quad=0, byte_idx=0, busy=0, done=0.
//  - On start in IDLE, all config inputs are latched. Config changes afterwards are ignored.
//  - start is ignored while busy.
//  - Counted phases CMD/ADDR/DUMMY/DATA/CS_HOLD:
//    - cs_n=0 and cnt_start=1 in every cycle of the phase.
//    - cnt_target holds the phase length N.
//    - The phase lasts exactly N cycles; cnt_done is high in its last cycle.
//    - The state advances at the end of the cnt_done cycle.
//  - Back-to-back counted phases keep cnt_start high continuously. cnt_target switches
//    in the first cycle of the new phase; the counter is in its clear cycle then.
//  - Phase lengths:
//    - CMD   = 8, or 2 if cmd_quad
//    - ADDR  = 24, or 6 if addr_quad
//    - DUMMY = dummy_cycles; a value of 1 is promoted to 2 (counter minimum)
//    - DATA  = 8, or 2 if data_quad, per byte
//  - Order: IDLE -> CMD -> [ADDR] -> [DUMMY] -> [DATA x data_bytes] -> [CS_HOLD] -> DONE -> IDLE.
//    Skipped phases take zero cycles.
//  - DATA: byte_idx increments on each cnt_done. The sequencer leaves DATA on the
//    cnt_done where byte_idx == data_bytes-1. byte_idx resets to 0 in IDLE.
//  - DONE lasts 1 cycle: cs_n=1, cnt_start=0, done=1. The state then returns to IDLE.
//  - abort in any busy state: next cycle is IDLE with reset-equivalent outputs.
//    No done pulse. abort takes priority over cnt_done in the same cycle.
//  - abort in IDLE has no effect. start together with abort in IDLE: abort wins,
//    and the block stays IDLE.
//  - quad reflects the current phase; it is 0 in IDLE, DUMMY, CS_HOLD and DONE.
// CONFIGURATION
//  QSPI_SEQ_CS_HOLD_EN
//    - Defined: CS_HOLD is inserted before DONE for CS_HOLD_CYCLES cycles,
//      with cs_n=0 and cnt_start=1.
//    - Undefined: CS_HOLD does not exist; the last phase goes directly to DONE.
//      phase value 5 is never produced.
// TESTING
//  Testbench instantiates qspi_counter connected to cnt_*.
//  1. Reset, then start with cmd_quad=0, addr_en=0, dummy=0, bytes=0
//     -> CMD in cycles 1-8, cnt_target=8; DONE in cycle 9; done=1 only there.
//  2. All quad, addr_en=1, dummy=6, bytes=2, macro undefined
//     -> CMD 2 cycles, ADDR 6, DUMMY 6, DATA 2+2 with byte_idx 0 then 1.
//     -> cs_n low for 18 cycles, cnt_start never drops, done in cycle 19.
//  3. dummy=1 -> DUMMY lasts 2 cycles with cnt_target=2.
//     bytes=MAX_BYTES in single lane -> DATA lasts 64 cycles.
//  4. abort asserted in the 3rd ADDR cycle
//     -> next cycle IDLE, cs_n=1, cnt_start=0, no done.
//     -> a following start runs a full transaction correctly.
//  5. rst pulsed mid-DATA -> next cycle all outputs at reset values.
//     start pulsed while busy -> ignored, transaction length unchanged.
//  6. Macro defined, scenario 1 config
//     -> CS_HOLD in cycles 9-10 (phase=5, cs_n=0); DONE in cycle 11.

Source files
------------

// File: rtl/qspi_phase_sequencer.sv
// QSPI transaction phase sequencer: CMD -> [ADDR] -> [DUMMY] -> [DATA xN] -> [CS_HOLD] -> DONE.
// Optional CS_HOLD phase is enabled by defining QSPI_SEQ_CS_HOLD_EN.
module qspi_phase_sequencer #(
    parameter int MAX_BYTES      = 8,
    parameter int CS_HOLD_CYCLES = 2,
    parameter int BW             = $clog2(MAX_BYTES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          addr_en,
    input  logic          cmd_quad,
    input  logic          addr_quad,
    input  logic          data_quad,
    input  logic [4:0]    dummy_cycles,
    input  logic [BW-1:0] data_bytes,
    input  logic          cnt_done,
    output logic          cnt_start,
    output logic [4:0]    cnt_target,
    output logic          cs_n,
    output logic [2:0]    phase,
    output logic          quad,
    output logic [BW-1:0] byte_idx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_ADDR    = 3'd2,
        S_DUMMY   = 3'd3,
        S_DATA    = 3'd4,
        S_CS_HOLD = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t        state;
    state_t        nxt;
    state_t        after_cmd;
    state_t        after_addr;
    state_t        after_dummy;
    state_t        after_data;

    logic          cfg_cmd_quad;
    logic          cfg_addr_en;
    logic          cfg_addr_quad;
    logic          cfg_data_quad;
    logic [4:0]    cfg_dummy;
    logic [BW-1:0] cfg_bytes;

    logic          cmd_q;
    logic          last_byte;
    logic [4:0]    dummy_len;
    logic [4:0]    nxt_target;
    logic          nxt_quad;
    logic          nxt_counted;

    // Configuration is captured on the accepted start and held for the whole transaction.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            cfg_cmd_quad  <= cmd_quad;
            cfg_addr_en   <= addr_en;
            cfg_addr_quad <= addr_quad;
            cfg_data_quad <= data_quad;
            cfg_dummy     <= dummy_cycles;
            cfg_bytes     <= data_bytes;
        end
    end

`ifdef QSPI_SEQ_CS_HOLD_EN
    assign after_data = S_CS_HOLD;
`else
    assign after_data = S_DONE;
`endif
    assign after_dummy = (cfg_bytes != '0) ? S_DATA : after_data;
    assign after_addr  = (cfg_dummy != 5'd0) ? S_DUMMY : after_dummy;
    assign after_cmd   = cfg_addr_en ? S_ADDR : after_addr;

    // CMD is entered straight from IDLE, before the latched copy is valid.
    assign cmd_q     = (state == S_IDLE) ? cmd_quad : cfg_cmd_quad;
    assign last_byte = (byte_idx == BW'(cfg_bytes - 1'b1));
    assign dummy_len = (cfg_dummy == 5'd1) ? 5'd2 : cfg_dummy;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    if (start) nxt = S_CMD;
            S_CMD:     if (cnt_done) nxt = after_cmd;
            S_ADDR:    if (cnt_done) nxt = after_addr;
            S_DUMMY:   if (cnt_done) nxt = after_dummy;
            S_DATA:    if (cnt_done && last_byte) nxt = after_data;
            S_CS_HOLD: if (cnt_done) nxt = S_DONE;
            S_DONE:    nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
        if (abort) nxt = S_IDLE;
    end

    always_comb begin
        nxt_target  = 5'd0;
        nxt_quad    = 1'b0;
        nxt_counted = 1'b1;
        case (nxt)
            S_CMD: begin
                nxt_target = cmd_q ? 5'd2 : 5'd8;
                nxt_quad   = cmd_q;
            end
            S_ADDR: begin
                nxt_target = cfg_addr_quad ? 5'd6 : 5'd24;
                nxt_quad   = cfg_addr_quad;
            end
            S_DUMMY:   nxt_target = dummy_len;
            S_DATA: begin
                nxt_target = cfg_data_quad ? 5'd2 : 5'd8;
                nxt_quad   = cfg_data_quad;
            end
            S_CS_HOLD: nxt_target = 5'(CS_HOLD_CYCLES);
            default:   nxt_counted = 1'b0;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cs_n       <= 1'b1;
            cnt_start  <= 1'b0;
            cnt_target <= 5'd0;
            quad       <= 1'b0;
            byte_idx   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= nxt;
            cs_n       <= ~nxt_counted;
            cnt_start  <= nxt_counted;
            cnt_target <= nxt_target;
            quad       <= nxt_quad;
            busy       <= (nxt != S_IDLE);
            done       <= (nxt == S_DONE);
            if (nxt == S_IDLE)
                byte_idx <= '0;
            else if (state == S_DATA && cnt_done && !last_byte)
                byte_idx <= byte_idx + 1'b1;
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_qspi_phase_sequencer.sv
// Scoreboard bench for qspi_phase_sequencer with a behavioural phase counter on cnt_*.
// Per-cycle expected outputs are queued when a transaction is launched and compared at negedge.
module tb_qspi_phase_sequencer;

    localparam int MAX_BYTES = 8;
    localparam int BW        = 4;
    localparam logic [31:0] M_ALL = 32'h0001_FFFF;
    localparam logic [31:0] M_BI  = 32'h0000_003C;
    localparam logic [31:0] M_TGT = 32'h0000_0F80;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          addr_en;
    logic          cmd_quad;
    logic          addr_quad;
    logic          data_quad;
    logic [4:0]    dummy_cycles;
    logic [BW-1:0] data_bytes;
    logic          cnt_done;
    logic          cnt_start;
    logic [4:0]    cnt_target;
    logic          cs_n;
    logic [2:0]    phase;
    logic          quad;
    logic [BW-1:0] byte_idx;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;
    int done_seen = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mask_q[$];
    logic [31:0] plan_e[$];
    logic [31:0] plan_m[$];

    always #5 clk = ~clk;

    qspi_phase_sequencer #(.MAX_BYTES(MAX_BYTES), .CS_HOLD_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .addr_en(addr_en),
        .cmd_quad(cmd_quad), .addr_quad(addr_quad), .data_quad(data_quad),
        .dummy_cycles(dummy_cycles), .data_bytes(data_bytes), .cnt_done(cnt_done),
        .cnt_start(cnt_start), .cnt_target(cnt_target), .cs_n(cs_n), .phase(phase),
        .quad(quad), .byte_idx(byte_idx), .busy(busy), .done(done)
    );

    // Phase counter: clears while idle and after each terminal count.
    logic [4:0] cnt;
    always @(posedge clk) begin
        if (rst || !cnt_start || cnt_done) cnt <= 5'd0;
        else cnt <= cnt + 5'd1;
    end
    assign cnt_done = cnt_start && (cnt == cnt_target - 5'd1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rec(input logic [2:0] ph, input logic csn, input logic cs,
                                        input logic [4:0] tgt, input logic q,
                                        input logic [3:0] bi, input logic dn, input logic bz);
        return {15'd0, ph, csn, cs, tgt, q, bi, dn, bz};
    endfunction

    function automatic logic [31:0] idle_rec();
        return rec(3'd0, 1'b1, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endfunction

    always @(negedge clk) begin
        logic [31:0] e;
        logic [31:0] m;
        logic [31:0] obs;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            m   = mask_q.pop_front();
            obs = rec(phase, cs_n, cnt_start, cnt_target, quad, byte_idx, done, busy);
            check($sformatf("t=%0t exp_phase=%0d", $time, e[16:14]), obs & m, e);
        end
        if (done === 1'b1) done_seen++;
    end

    task automatic push_phase(input int ph, input int n, input bit q, input int bi, input bit mask_bi);
        for (int i = 0; i < n; i++) begin
            plan_e.push_back(rec(3'(ph), 1'b0, 1'b1, 5'(n), q, mask_bi ? 4'd0 : 4'(bi), 1'b0, 1'b1));
            plan_m.push_back(mask_bi ? (M_ALL & ~M_BI) : M_ALL);
        end
    endtask

    task automatic build_plan(input bit cq, input bit ae, input bit aq, input bit dq,
                              input int dmy, input int nbytes);
        plan_e.delete();
        plan_m.delete();
        push_phase(1, cq ? 2 : 8, cq, 0, 1'b0);
        if (ae) push_phase(2, aq ? 6 : 24, aq, 0, 1'b0);
        if (dmy > 0) push_phase(3, (dmy == 1) ? 2 : dmy, 1'b0, 0, 1'b0);
        for (int b = 0; b < nbytes; b++) push_phase(4, dq ? 2 : 8, dq, b, 1'b0);
`ifdef QSPI_SEQ_CS_HOLD_EN
        push_phase(5, 2, 1'b0, 0, 1'b1);
`endif
        plan_e.push_back(rec(3'd6, 1'b1, 1'b0, 5'd0, 1'b0, 4'd0, 1'b1, 1'b1));
        plan_m.push_back(M_ALL & ~M_BI & ~M_TGT);
    endtask

    // Launch one transaction; abort_at/rst_at/busy_start_at are cycle numbers (0 = unused).
    task automatic run(input string name, input bit cq, input bit ae, input bit aq, input bit dq,
                       input int dmy, input int nbytes,
                       input int abort_at, input int rst_at, input int busy_start_at);
        int cyc;
        int d0;
        int cut;
        @(negedge clk);
        #1;
        cmd_quad = cq; addr_en = ae; addr_quad = aq; data_quad = dq;
        dummy_cycles = 5'(dmy); data_bytes = BW'(nbytes);
        start = 1'b1;
        build_plan(cq, ae, aq, dq, dmy, nbytes);
        cut = (abort_at > 0) ? abort_at : rst_at;
        for (int i = 0; i < plan_e.size(); i++) begin
            if (cut == 0 || i < cut) begin
                exp_q.push_back(plan_e[i]);
                mask_q.push_back(plan_m[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(idle_rec());
            mask_q.push_back(M_ALL);
        end
        d0 = done_seen;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 400) begin
            @(negedge clk);
            #1;
            cyc++;
            start        = (cyc == busy_start_at);
            cmd_quad     = 1'($urandom);
            addr_en      = 1'($urandom);
            addr_quad    = 1'($urandom);
            data_quad    = 1'($urandom);
            dummy_cycles = 5'($urandom_range(0, 31));
            data_bytes   = BW'($urandom_range(0, MAX_BYTES));
            abort        = (cyc == abort_at);
            rst          = (cyc == rst_at);
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        check({name, " drain"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        mask_q.delete();
        check({name, " done_count"}, 32'(done_seen - d0), (cut == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        addr_en = 1'b0; cmd_quad = 1'b0; addr_quad = 1'b0; data_quad = 1'b0;
        dummy_cycles = 5'd0; data_bytes = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        exp_q.push_back(idle_rec());
        mask_q.push_back(M_ALL);
        @(negedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(idle_rec());
        mask_q.push_back(M_ALL);
        @(negedge clk);
        #1;
        check("reset drain", 32'(exp_q.size()), 32'd0);

        run("single_cmd",   1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        run("all_quad",     1'b1, 1'b1, 1'b1, 1'b1, 6, 2, 0, 0, 0);
        run("dummy1_max",   1'b0, 1'b0, 1'b0, 1'b0, 1, MAX_BYTES, 0, 0, 0);
        run("abort_addr",   1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 11, 0, 0);
        run("after_abort",  1'b1, 1'b1, 1'b0, 1'b1, 3, 3, 0, 0, 0);
        run("abort_on_done", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 8, 0, 0);
        run("rst_data",     1'b1, 1'b0, 1'b0, 1'b0, 0, 2, 0, 6, 0);
        run("busy_start",   1'b0, 1'b1, 1'b1, 1'b0, 4, 1, 0, 0, 5);

        // start and abort together in IDLE: abort wins.
        @(negedge clk);
        #1;
        start = 1'b1; abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(idle_rec());
            mask_q.push_back(M_ALL);
        end
        @(negedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        check("start_abort drain", 32'(exp_q.size()), 32'd0);

        run("final", 1'b0, 1'b1, 1'b1, 1'b1, 2, 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
